ex_mem_skid: RTL and testbench

- Pipeline buffer between the EX stage and the MEM stage.
- EX is the ALU: adder, logic, compare and the barrel shifter producing the 32-bit result.
- Captures the EX result bundle (ALU result, store data, destination register, control bits) in a 2-entry skid buffer with valid/ready handshakes on both sides.
- A MEM-side stall therefore never forms a combinational ready path back through the ALU.
- Supports a pipeline flush for branch mispredict and exceptions.

---
 rtl/ex_mem_skid_if.sv | 42 ++++
 rtl/ex_mem_skid.sv | 122 ++++++++++++
 tb/tb_ex_mem_skid.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_skid_if.sv
// EX->MEM bundle interface: upstream (in_*) and downstream (out_*) handshakes.
// Handshake rule, both sides: a transfer happens on a rising clk edge exactly
// when valid && ready are both high; the sender holds its fields stable while
// valid && !ready; ready never depends combinationally on the same-side valid.
interface ex_mem_skid_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic [DW-1:0] in_sdata;
    logic [AW-1:0] in_rd;
    logic          in_regwr;
    logic          in_memrd;
    logic          in_memwr;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [DW-1:0] out_sdata;
    logic [AW-1:0] out_rd;
    logic          out_regwr;
    logic          out_memrd;
    logic          out_memwr;

    // Buffer side: consumes the EX bundle, produces the MEM bundle.
    modport slave (
        input  in_valid, in_result, in_sdata, in_rd, in_regwr, in_memrd, in_memwr,
        output in_ready,
        output out_valid, out_result, out_sdata, out_rd, out_regwr, out_memrd, out_memwr,
        input  out_ready
    );

    // Environment side: drives EX bundle and MEM ready, observes the rest.
    modport master (
        output in_valid, in_result, in_sdata, in_rd, in_regwr, in_memrd, in_memwr,
        input  in_ready,
        input  out_valid, out_result, out_sdata, out_rd, out_regwr, out_memrd, out_memwr,
        output out_ready
    );
endinterface

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register built as a 2-entry skid buffer.
// Head entry (slot 0) drives the MEM outputs directly from flops; the skid
// entry (slot 1) absorbs the one bundle EX may send while MEM stalls, so
// in_ready is a flop and never depends combinationally on out_ready.
// Optional macro EX_MEM_SKID_FWD_EN adds the EX bypass outputs
// fwd_valid / fwd_rd / fwd_data taken from the head entry.
module ex_mem_skid #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    ex_mem_skid_if.slave  bus,
`ifdef EX_MEM_SKID_FWD_EN
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_rd,
    output logic [DW-1:0] fwd_data,
`endif
    output logic [1:0]    occupancy
);

    typedef struct packed {
        logic [DW-1:0] result;
        logic [DW-1:0] sdata;
        logic [AW-1:0] rd;
        logic          regwr;
        logic          memrd;
        logic          memwr;
    } bundle_t;

    // Occupancy doubles as the buffer state: 0 empty, 1 head only, 2 full.
    logic [1:0] occ_q, occ_d;
    logic       in_ready_q, in_ready_d;
    bundle_t    head_q, head_d;
    bundle_t    skid_q, skid_d;
    bundle_t    in_bundle;
    logic       accept;
    logic       pop;

    assign in_bundle = '{result: bus.in_result, sdata: bus.in_sdata, rd: bus.in_rd,
                         regwr: bus.in_regwr, memrd: bus.in_memrd, memwr: bus.in_memwr};
    assign accept = bus.in_valid && in_ready_q;
    assign pop    = (occ_q != 2'd0) && bus.out_ready;

    // State register: reset empties the buffer and opens the input at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q      <= 2'd0;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    // Next state: flush wins over everything; otherwise move per occupancy.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        if (flush) begin
            // Same-cycle accept is dropped; a same-cycle pop was already seen by MEM.
            occ_d = 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (accept) begin
                        occ_d  = 2'd1;
                        head_d = in_bundle;
                    end
                end
                2'd1: begin
                    if (accept && !pop) begin
                        occ_d  = 2'd2;
                        skid_d = in_bundle;
                    end else if (pop && !accept) begin
                        occ_d  = 2'd0;
                    end else if (pop && accept) begin
                        head_d = in_bundle;
                    end
                end
                2'd2: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        occ_d  = 2'd1;
                        head_d = skid_q;
                    end
                end
                default: occ_d = 2'd0;
            endcase
        end
        in_ready_d = (occ_d != 2'd2);
    end

    // Outputs: straight from head flops; control bits masked when nothing is valid.
    always_comb begin
        bus.in_ready   = in_ready_q;
        bus.out_valid  = (occ_q != 2'd0);
        bus.out_result = head_q.result;
        bus.out_sdata  = head_q.sdata;
        bus.out_rd     = head_q.rd;
        bus.out_regwr  = head_q.regwr && (occ_q != 2'd0);
        bus.out_memrd  = head_q.memrd && (occ_q != 2'd0);
        bus.out_memwr  = head_q.memwr && (occ_q != 2'd0);
        occupancy      = occ_q;
    end

`ifdef EX_MEM_SKID_FWD_EN
    // Bypass: only register-writing non-loads with a nonzero destination qualify.
    always_comb begin
        fwd_valid = (occ_q != 2'd0) && head_q.regwr && !head_q.memrd && (head_q.rd != '0);
        fwd_rd    = head_q.rd;
        fwd_data  = head_q.result;
    end
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: queue-based reference model, per-cycle compare
// process, directed scenarios with literal expectations, then random traffic.
module tb_ex_mem_skid;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int W  = 2 * DW + AW + 3;   // {result, sdata, rd, regwr, memrd, memwr}

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;
`ifdef EX_MEM_SKID_FWD_EN
    logic          fwd_valid;
    logic [AW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;
`endif

    ex_mem_skid_if #(.DW(DW), .AW(AW)) bus ();

    ex_mem_skid #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus.slave),
`ifdef EX_MEM_SKID_FWD_EN
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
`endif
        .occupancy (occupancy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model / scoreboard ----------------
    logic [W-1:0]  exp_q[$];      // entries the buffer must hold, head first
    logic [DW-1:0] pop_log[$];    // results delivered to MEM, in order
    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;
    bit  seen_dead = 1'b0;

    function automatic logic [W-1:0] mk(input logic [DW-1:0] res, input logic [DW-1:0] sd,
                                        input logic [AW-1:0] rd, input logic rw,
                                        input logic mr, input logic mw);
        return {res, sd, rd, rw, mr, mw};
    endfunction

    function automatic logic [W-1:0] dut_head();
        return {bus.out_result, bus.out_sdata, bus.out_rd,
                bus.out_regwr, bus.out_memrd, bus.out_memwr};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model advances by the buffer's transfer rules.
    task automatic cycle(input bit v, input bit rdy, input bit fl, input logic [W-1:0] b);
        logic [W-1:0] head;
        bit pop, acc;
        bus.in_valid  = v;
        bus.out_ready = rdy;
        flush         = fl;
        {bus.in_result, bus.in_sdata, bus.in_rd, bus.in_regwr, bus.in_memrd, bus.in_memwr} = b;
        @(posedge clk);
        pop = (exp_q.size() > 0) && rdy;
        acc = v && (exp_q.size() < 2);
        if (pop) begin
            head = exp_q[0];
            pop_log.push_back(head[W-1 -: DW]);
        end
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(b);
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, rdy, 1'b0, '0);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            logic [W-1:0] h;
            n = exp_q.size();
            check("occupancy", W'(occupancy), W'(n));
            check("in_ready", W'(bus.in_ready), W'(n < 2));
            check("out_valid", W'(bus.out_valid), W'(n != 0));
            if (n != 0) begin
                h = exp_q[0];
                check("head", dut_head(), h);
            end else begin
                check("ctrl_idle", W'({bus.out_regwr, bus.out_memrd, bus.out_memwr}), '0);
                h = '0;
            end
`ifdef EX_MEM_SKID_FWD_EN
            check("fwd_valid", W'(fwd_valid),
                  W'((n != 0) && h[2] && !h[1] && (h[7:3] != '0)));
            if (n != 0) begin
                check("fwd_rd", W'(fwd_rd), W'(h[7:3]));
                check("fwd_data", W'(fwd_data), W'(h[W-1 -: DW]));
            end
`endif
            if (bus.out_valid && bus.out_result == 32'hDEADBEEF) seen_dead = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int pops0;
        logic [W-1:0] st;
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_result = '0; bus.in_sdata = '0; bus.in_rd = '0;
        bus.in_regwr = 1'b0; bus.in_memrd = 1'b0; bus.in_memwr = 1'b0;

        // Reset state, before any clock edge.
        #2;
        check("rst_out_valid", W'(bus.out_valid), '0);
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_occupancy", W'(occupancy), '0);
        check("rst_ctrl", W'({bus.out_regwr, bus.out_memrd, bus.out_memwr}), '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Streaming with MEM always ready: one-cycle latency, steady occupancy 1.
        pops0 = pop_log.size();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0, mk(32'h1 << i, 32'(i), AW'(i + 1), 1'b1, 1'b0, 1'b0));
            check("stream_result", W'(bus.out_result), W'(32'h1 << i));
            check("stream_rd", W'(bus.out_rd), W'(i + 1));
            check("stream_occ", W'(occupancy), W'(1));
        end
        idle(1'b1);
        check("stream_pops", W'(pop_log.size() - pops0), W'(8));
        check("stream_last", W'(pop_log[pop_log.size() - 1]), W'(32'h80));

        // Stall fills both slots; release drains in order.
        cycle(1'b1, 1'b0, 1'b0, mk(32'hAAAA0000, '0, 5'd3, 1'b1, 1'b0, 1'b0));
        cycle(1'b1, 1'b0, 1'b0, mk(32'h0000BBBB, '0, 5'd4, 1'b1, 1'b0, 1'b0));
        check("full_occ", W'(occupancy), W'(2));
        check("full_in_ready", W'(bus.in_ready), '0);
        check("full_head", W'(bus.out_result), W'(32'hAAAA0000));
        cycle(1'b1, 1'b0, 1'b0, mk(32'hCCCCCCCC, '0, 5'd5, 1'b1, 1'b0, 1'b0)); // refused
        check("full_hold", W'(bus.out_result), W'(32'hAAAA0000));
        idle(1'b1);
        check("drain_head", W'(bus.out_result), W'(32'h0000BBBB));
        check("drain_in_ready", W'(bus.in_ready), W'(1));
        idle(1'b1);
        check("drain_order0", W'(pop_log[pop_log.size() - 2]), W'(32'hAAAA0000));
        check("drain_order1", W'(pop_log[pop_log.size() - 1]), W'(32'h0000BBBB));
        check("drain_empty", W'(occupancy), '0);

        // Flush while full with a same-cycle input that must be dropped.
        seen_dead = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, mk(32'h11111111, '0, 5'd1, 1'b1, 1'b0, 1'b0));
        cycle(1'b1, 1'b0, 1'b0, mk(32'h22222222, '0, 5'd2, 1'b1, 1'b0, 1'b0));
        cycle(1'b1, 1'b0, 1'b1, mk(32'hDEADBEEF, '0, 5'd9, 1'b1, 1'b0, 1'b1));
        check("flush_occ", W'(occupancy), '0);
        check("flush_valid", W'(bus.out_valid), '0);
        check("flush_in_ready", W'(bus.in_ready), W'(1));
        check("flush_ctrl", W'({bus.out_regwr, bus.out_memrd, bus.out_memwr}), '0);
        repeat (3) idle(1'b1);
        check("flush_no_dead", W'(seen_dead), '0);

        // Store held stable for three stalled cycles, popped on the fourth.
        st = mk(32'h00001004, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, st);
        for (int i = 0; i < 3; i++) begin
            check("store_hold", dut_head(), st);
            idle(1'b0);
        end
        check("store_hold4", dut_head(), st);
        idle(1'b1);
        check("store_popped", W'(pop_log[pop_log.size() - 1]), W'(32'h00001004));
        check("store_empty", W'(occupancy), '0);

`ifdef EX_MEM_SKID_FWD_EN
        cycle(1'b1, 1'b0, 1'b0, mk(32'hFFFF8000, '0, 5'd8, 1'b1, 1'b0, 1'b0));
        check("fwd_alu", W'(fwd_valid), W'(1));
        check("fwd_alu_data", W'(fwd_data), W'(32'hFFFF8000));
        check("fwd_alu_rd", W'(fwd_rd), W'(8));
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, mk(32'hFFFF8000, '0, 5'd8, 1'b1, 1'b1, 1'b0));
        check("fwd_load", W'(fwd_valid), '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, mk(32'hFFFF8000, '0, 5'd0, 1'b1, 1'b0, 1'b0));
        check("fwd_r0", W'(fwd_valid), '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
`endif

        // Randomized traffic with bursty MEM stalls and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  (i % 64 < 32) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 24) == 0,
                  mk($urandom, $urandom, AW'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1))));
        end

        // Asynchronous reset while full: outputs clear without a clock edge.
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, mk(32'h33333333, '0, 5'd6, 1'b1, 1'b0, 1'b1));
        cycle(1'b1, 1'b0, 1'b0, mk(32'h44444444, '0, 5'd7, 1'b1, 1'b0, 1'b1));
        check("prerst_occ", W'(occupancy), W'(2));
        bus.in_valid = 1'b0;
        #2;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("mrst_valid", W'(bus.out_valid), '0);
        check("mrst_occ", W'(occupancy), '0);
        check("mrst_in_ready", W'(bus.in_ready), W'(1));
        check("mrst_ctrl", W'({bus.out_regwr, bus.out_memwr}), '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, mk(32'h55555555, '0, 5'd2, 1'b1, 1'b0, 1'b0));
        check("post_rst_result", W'(bus.out_result), W'(32'h55555555));
        repeat (3) idle(1'b1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
